// File: rtl/tdm_mux8_pkg.sv
// Shared constants, FSM state type and the demux lane mapping used by the
// TDM 8-to-1 transmitter.
package tdm_mux8_pkg;

   localparam int LANES = 8;
   localparam int SEL_W = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Slot code c carries lane {c[2], ~c[1], ~c[0]} to match the demux lane order.
   function automatic logic [SEL_W-1:0] lane_of(input logic [SEL_W-1:0] code);
      return {code[2], ~code[1:0]};
   endfunction

endpackage

// File: rtl/tdm_mux8_tx_mux8_1.sv
// Combinational 8:1 selector that picks the frame bit for a slot code using
// the demux lane mapping.
module mux8_1
   import tdm_mux8_pkg::*;
(
   input  logic [LANES-1:0] d,
   input  logic [SEL_W-1:0] code,
   output logic             q
);

   assign q = d[lane_of(code)];

endmodule

// File: rtl/tdm_mux8_tx.sv
// Time-division 8-to-1 transmitter: takes a parallel frame over valid/ready and
// sends one lane per slot on sdo with its lane code on sel and enable on en.
module tdm_mux8_tx
   import tdm_mux8_pkg::*;
#(
   parameter int HOLD  = 1,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [LANES-1:0] in_data,
   output logic             in_ready,
   input  logic             out_ready,
   output logic             en,
   output logic [SEL_W-1:0] sel,
   output logic             sdo,
   output logic             frame_start,
   output logic             frame_done
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);
   localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(LANES - 1);

   state_t           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [LANES-1:0] frame_q, frame_d;
   logic             sdo_q, sdo_d;
   logic             start_q, start_d;
   logic             done_q, done_d;
   logic             sdo_next;
   logic             beat, slot_end, frame_end, accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= '0;
         hold_q  <= '0;
         frame_q <= '0;
         sdo_q   <= 1'b0;
         start_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         hold_q  <= hold_d;
         frame_q <= frame_d;
         sdo_q   <= sdo_d;
         start_q <= start_d;
         done_q  <= done_d;
      end
   end

   // A new frame may be taken on the completing beat of slot 111, so there is no bubble.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      hold_d  = hold_q;
      frame_d = frame_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SHIFT;
               sel_d   = '0;
               hold_d  = '0;
               frame_d = in_data;
            end
         end
         SHIFT: begin
            if (beat) begin
               if (!slot_end) begin
                  hold_d = hold_q + CNT_W'(1);
               end else begin
                  hold_d = '0;
                  if (frame_end) begin
                     done_d = 1'b1;
                     sel_d  = '0;
                     if (accept) begin
                        frame_d = in_data;
                     end else begin
                        state_d = IDLE;
                     end
                  end else begin
                     sel_d = sel_q + SEL_W'(1);
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      en        = (state_q == SHIFT);
      beat      = en && out_ready;
      slot_end  = beat && (hold_q == HOLD_LAST);
      frame_end = slot_end && (sel_q == SEL_LAST);
      in_ready  = !rst && ((state_q == IDLE) || frame_end);
      accept    = in_valid && in_ready;
   end

   mux8_1 u_mux (
      .d    (frame_d),
      .code (sel_d),
      .q    (sdo_next)
   );

   assign sdo_d   = (state_d == SHIFT) ? sdo_next : 1'b0;
   assign start_d = (state_d == SHIFT) && (sel_d == '0);

   assign sel         = sel_q;
   assign sdo         = sdo_q;
   assign frame_start = start_q;
   assign frame_done  = done_q;

endmodule

// File: tb/tb_tdm_mux8_tx.sv
// Scoreboard bench for tdm_mux8_tx: one HOLD=1 and one HOLD=3 instance, the
// active one is checked slot by slot against a frame-level reference model.
module tb_tdm_mux8_tx;

   typedef struct {
      logic [2:0] sel;
      logic       sdo;
      logic       fs;
      logic       last;
   } slot_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       out_ready = 1'b1;
   logic       act = 1'b0;
   logic       mon_on = 1'b0;

   logic       in_valid0, in_valid1, out_ready0, out_ready1;
   logic       in_ready0, en0, sdo0, fs0, fd0;
   logic       in_ready1, en1, sdo1, fs1, fd1;
   logic [2:0] sel0, sel1;

   logic       m_in_ready, m_en, m_sdo, m_fs, m_fd;
   logic [2:0] m_sel;
   logic [7:0] y;

   slot_t      exp_q[$];
   logic       done_exp = 1'b0;
   int         tests = 0;
   int         fails = 0;
   int         en_count = 0;
   int         en_run = 0;
   int         max_run = 0;
   logic [7:0] y_acc = 8'h00;
   logic [7:0] sdo_log = 8'h00;

   always #5 clk = ~clk;

   assign in_valid0  = in_valid && !act;
   assign in_valid1  = in_valid && act;
   assign out_ready0 = act ? 1'b1 : out_ready;
   assign out_ready1 = act ? out_ready : 1'b1;

   tdm_mux8_tx #(.HOLD(1), .CNT_W(4)) dut_h1 (
      .clk(clk), .rst(rst), .in_valid(in_valid0), .in_data(in_data),
      .in_ready(in_ready0), .out_ready(out_ready0), .en(en0), .sel(sel0),
      .sdo(sdo0), .frame_start(fs0), .frame_done(fd0)
   );

   tdm_mux8_tx #(.HOLD(3), .CNT_W(2)) dut_h3 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data),
      .in_ready(in_ready1), .out_ready(out_ready1), .en(en1), .sel(sel1),
      .sdo(sdo1), .frame_start(fs1), .frame_done(fd1)
   );

   always_comb begin
      m_in_ready = act ? in_ready1 : in_ready0;
      m_en       = act ? en1 : en0;
      m_sel      = act ? sel1 : sel0;
      m_sdo      = act ? sdo1 : sdo0;
      m_fs       = act ? fs1 : fs0;
      m_fd       = act ? fd1 : fd0;
   end

   // Existing downstream 1-to-8 demux used for loopback.
   always_comb begin
      y = 8'h00;
      if (m_en) y[{m_sel[2], ~m_sel[1:0]}] = m_sdo;
   end

   function automatic int lane_model(input int c);
      return (c < 4) ? (3 - c) : (11 - c);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic timeoutFail(input string name);
      tests++;
      fails++;
      $display("[TB] FAIL %s: timeout waiting for DUT at %0t", name, $time);
   endtask

   // Monitor: outputs of the current cycle are compared with the head of the queue.
   always @(negedge clk) begin
      if (mon_on) begin
         checkOutput("en", m_en, exp_q.size() != 0);
         checkOutput("frame_done", m_fd, done_exp);
         checkOutput("in_ready", m_in_ready,
                     !rst && (exp_q.size() == 0 || (exp_q[0].last && out_ready)));
         done_exp = 1'b0;
         if (m_en) begin
            en_run++;
            if (en_run > max_run) max_run = en_run;
         end else begin
            en_run = 0;
         end
         if (m_en && exp_q.size() != 0) begin
            checkOutput("sel", m_sel, exp_q[0].sel);
            checkOutput("sdo", m_sdo, exp_q[0].sdo);
            checkOutput("frame_start", m_fs, exp_q[0].fs);
            if (out_ready && !rst) begin
               en_count++;
               y_acc   = y_acc | y;
               sdo_log = {sdo_log[6:0], m_sdo};
               if (exp_q[0].last) done_exp = 1'b1;
               void'(exp_q.pop_front());
            end
         end
         if (rst) begin
            exp_q.delete();
            done_exp = 1'b0;
         end else if (in_valid && m_in_ready) begin
            for (int c = 0; c < 8; c++) begin
               for (int h = 0; h < (act ? 3 : 1); h++) begin
                  slot_t s;
                  s.sel  = 3'(c);
                  s.sdo  = in_data[lane_model(c)];
                  s.fs   = (c == 0);
                  s.last = (c == 7) && (h == (act ? 2 : 0));
                  exp_q.push_back(s);
               end
            end
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] d, input bit keep);
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (m_in_ready) begin
            @(posedge clk);
            #1;
            if (!keep) begin
               in_valid = 1'b0;
               in_data  = 8'($urandom);
            end
            return;
         end
      end
      in_valid = 1'b0;
      timeoutFail("accept");
   endtask

   task automatic waitIdle();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !m_en) begin
            repeat (2) @(negedge clk);
            @(posedge clk);
            #1;
            return;
         end
      end
      timeoutFail("idle");
   endtask

   task automatic waitSel(input logic [2:0] code);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (m_en && m_sel == code) return;
      end
      timeoutFail("wait_sel");
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      in_valid = 1'b1;
      in_data  = 8'hFF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_in_ready", m_in_ready, 0);
      checkOutput("rst_en", m_en, 0);
      checkOutput("rst_sel", m_sel, 0);
      checkOutput("rst_sdo", m_sdo, 0);
      checkOutput("rst_frame_start", m_fs, 0);
      checkOutput("rst_frame_done", m_fd, 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst      = 1'b0;
      mon_on   = 1'b1;

      // HOLD=1, single frame A5
      applyStimulus(8'hA5, 0);
      waitIdle();
      checkOutput("a5_sdo_seq", sdo_log, 8'b01011010);

      // Back-to-back FF then 00
      max_run = 0;
      applyStimulus(8'hFF, 1);
      applyStimulus(8'h00, 0);
      waitIdle();
      checkOutput("b2b_run", max_run, 16);

      // Reset while sel=101
      applyStimulus(8'($urandom), 0);
      waitSel(3'b101);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("abort_en", m_en, 0);
      checkOutput("abort_sel", m_sel, 0);
      repeat (3) @(posedge clk);
      #1;
      applyStimulus(8'h3C, 0);
      waitIdle();
      checkOutput("3c_sdo_seq", sdo_log, 8'b11000011);

      // Loopback through the demux with one-hot frames
      for (int k = 0; k < 8; k++) begin
         y_acc = 8'h00;
         applyStimulus(8'(1 << k), 0);
         waitIdle();
         checkOutput("loopback", y_acc, 32'(1 << k));
      end

      // HOLD=3 instance
      act = 1'b1;
      @(posedge clk);
      #1;
      en_count = 0;
      applyStimulus(8'h81, 0);
      waitIdle();
      checkOutput("h3_frame_len", en_count, 24);

      // Stall for 5 cycles while sel=010
      applyStimulus(8'($urandom), 0);
      waitSel(3'b010);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      out_ready = 1'b1;
      waitIdle();

      // Randomized traffic on both instances
      for (int a = 0; a < 2; a++) begin
         act = a[0];
         @(posedge clk);
         #1;
         for (int i = 0; i < 250; i++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
         waitIdle();
      end

      mon_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
